// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard control slice.
// Holds the mul/div FSM encoding, the $0 constant and the register match rule.
package hazard_pkg;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A source only conflicts with a pending write when it is really read
   // and the destination is not $0, which never holds a live value.
   function automatic logic reg_match(input logic [4:0] src,
                                      input logic [4:0] wreg,
                                      input logic       used);
      return used && (src == wreg) && (wreg != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the ID/EX/MEM pipeline and the hazard control unit.
// master: pipeline side (drives stage info, takes controls); slave: hazard unit.
interface hazard_ctrl_unit_if #(
   parameter int CNT_W = 32
);

   logic [4:0]       ID_rs;
   logic [4:0]       ID_rt;
   logic             ID_uses_rt;
   logic             ID_branch;
   logic             ID_taken;
   logic             ID_hilo_use;
   logic             IDEX_memread;
   logic             IDEX_regwrite;
   logic [4:0]       IDEX_wreg;
   logic             EXMEM_memread;
   logic [4:0]       EXMEM_wreg;
   logic             EX_muldiv_start;
   logic             PC_write;
   logic             IFID_write;
   logic             IF_flush;
   logic             IDEX_bubble;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ID_rs, ID_rt, ID_uses_rt, ID_branch, ID_taken, ID_hilo_use,
      output IDEX_memread, IDEX_regwrite, IDEX_wreg,
      output EXMEM_memread, EXMEM_wreg, EX_muldiv_start,
      input  PC_write, IFID_write, IF_flush, IDEX_bubble,
      input  md_busy, stall_cnt, flush_cnt
   );

   modport slave (
      input  ID_rs, ID_rt, ID_uses_rt, ID_branch, ID_taken, ID_hilo_use,
      input  IDEX_memread, IDEX_regwrite, IDEX_wreg,
      input  EXMEM_memread, EXMEM_wreg, EX_muldiv_start,
      output PC_write, IFID_write, IF_flush, IDEX_bubble,
      output md_busy, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/muldiv_tracker.sv
// Tracks the multi-cycle mul/div unit: busy for MULDIV_LAT cycles after start.
// Ports: clk, rst (async high), start (issue from EX), md_busy (registered).
module muldiv_tracker
   import hazard_pkg::*;
#(
   parameter int MULDIV_LAT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic md_busy
);

   md_state_t  state, state_nxt;
   logic [7:0] md_cnt, md_cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= MD_IDLE;
         md_cnt <= 8'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // md_cnt counts the remaining busy cycles after the current one.
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      unique case (state)
         MD_IDLE: begin
            if (start) begin
               state_nxt  = MD_BUSY;
               md_cnt_nxt = 8'(MULDIV_LAT - 1);
            end
         end
         MD_BUSY: begin
            if (md_cnt == 8'd0) begin
               state_nxt = MD_IDLE;
            end else begin
               md_cnt_nxt = md_cnt - 8'd1;
            end
         end
         default: begin
            state_nxt  = MD_IDLE;
            md_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_comb begin
      md_busy = (state == MD_BUSY);
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard control: load-use, branch-operand and mul/div stalls, branch flush.
// Ports: clk, rst (async high), h (slave bundle: stage info in, IF/ID controls and counters out).
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int MULDIV_LAT = 32,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   hazard_ctrl_unit_if.slave   h
);

   logic lu_haz;
   logic br_haz;
   logic md_haz;
   logic stall;
   logic flush;
   logic md_busy;

   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   muldiv_tracker #(
      .MULDIV_LAT (MULDIV_LAT)
   ) u_md (
      .clk     (clk),
      .rst     (rst),
      .start   (h.EX_muldiv_start),
      .md_busy (md_busy)
   );

   always_comb begin
      lu_haz = h.IDEX_memread &&
               (reg_match(h.ID_rs, h.IDEX_wreg, 1'b1) ||
                reg_match(h.ID_rt, h.IDEX_wreg, h.ID_uses_rt));
      // beq/bne compare in ID, so any ALU result still in EX is too late,
      // and a load in MEM has not reached the forwarding point yet.
      br_haz = h.ID_branch &&
               ((h.IDEX_regwrite &&
                 (reg_match(h.ID_rs, h.IDEX_wreg, 1'b1) ||
                  reg_match(h.ID_rt, h.IDEX_wreg, h.ID_uses_rt))) ||
                (h.EXMEM_memread &&
                 (reg_match(h.ID_rs, h.EXMEM_wreg, 1'b1) ||
                  reg_match(h.ID_rt, h.EXMEM_wreg, h.ID_uses_rt))));
      md_haz = h.ID_hilo_use && md_busy;
      stall  = lu_haz || br_haz || md_haz;
      // ID_taken is computed from possibly stale operands while stalled.
      flush  = !stall && h.ID_taken;
   end

   always_comb begin
      h.PC_write    = 1'b1;
      h.IFID_write  = 1'b1;
      h.IF_flush    = 1'b0;
      h.IDEX_bubble = 1'b0;
      priority case (1'b1)
         rst: begin
            h.PC_write    = 1'b0;
            h.IFID_write  = 1'b0;
            h.IF_flush    = 1'b1;
            h.IDEX_bubble = 1'b1;
         end
         stall: begin
            h.PC_write    = 1'b0;
            h.IFID_write  = 1'b0;
            h.IDEX_bubble = 1'b1;
         end
         flush: begin
            h.IF_flush    = 1'b1;
         end
         default: begin
            h.PC_write    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      h.md_busy   = md_busy;
      h.stall_cnt = stall_cnt;
      h.flush_cnt = flush_cnt;
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (MULDIV_LAT=4, CNT_W=4).
// Inputs change 1ns after posedge; comb outputs sampled at negedge.
module tb_hazard_ctrl_unit;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   hazard_ctrl_unit_if #(.CNT_W(4)) hif ();

   hazard_ctrl_unit #(
      .MULDIV_LAT (4),
      .CNT_W      (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .h   (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         assert (!(hif.md_busy && hif.EX_muldiv_start))
            else $error("mul/div issued while busy");
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      hif.ID_rs           = 5'd0;
      hif.ID_rt           = 5'd0;
      hif.ID_uses_rt      = 1'b0;
      hif.ID_branch       = 1'b0;
      hif.ID_taken        = 1'b0;
      hif.ID_hilo_use     = 1'b0;
      hif.IDEX_memread    = 1'b0;
      hif.IDEX_regwrite   = 1'b0;
      hif.IDEX_wreg       = 5'd0;
      hif.EXMEM_memread   = 1'b0;
      hif.EXMEM_wreg      = 5'd0;
      hif.EX_muldiv_start = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input string tag, input logic pcw, input logic ifw,
                      input logic fl, input logic bub);
      @(negedge clk);
      check({tag, ".PC_write"},    32'(hif.PC_write),    32'(pcw));
      check({tag, ".IFID_write"},  32'(hif.IFID_write),  32'(ifw));
      check({tag, ".IF_flush"},    32'(hif.IF_flush),    32'(fl));
      check({tag, ".IDEX_bubble"}, 32'(hif.IDEX_bubble), 32'(bub));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      clear_in();

      // reset state
      step();
      step();
      ctl("rst", 1'b0, 1'b0, 1'b1, 1'b1);
      check("rst.stall_cnt", 32'(hif.stall_cnt), 32'd0);
      check("rst.flush_cnt", 32'(hif.flush_cnt), 32'd0);
      check("rst.md_busy",   32'(hif.md_busy),   32'd0);
      step();
      rst = 1'b0;
      ctl("rel", 1'b1, 1'b1, 1'b0, 1'b0);

      // load-use on rs
      step();
      hif.IDEX_memread = 1'b1;
      hif.IDEX_wreg    = 5'd8;
      hif.ID_rs        = 5'd8;
      ctl("lu", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("lu.stall_cnt", 32'(hif.stall_cnt), 32'd1);
      // $0 destination never stalls
      hif.IDEX_wreg = 5'd0;
      hif.ID_rs     = 5'd0;
      ctl("lu0", 1'b1, 1'b1, 1'b0, 1'b0);
      // rt match ignored when rt is not read
      step();
      hif.IDEX_wreg  = 5'd8;
      hif.ID_rs      = 5'd1;
      hif.ID_rt      = 5'd8;
      hif.ID_uses_rt = 1'b0;
      ctl("lu_nort", 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check("lu0.stall_cnt", 32'(hif.stall_cnt), 32'd1);
      clear_in();

      // branch on EX ALU result: stall beats taken
      hif.ID_branch     = 1'b1;
      hif.ID_rt         = 5'd9;
      hif.ID_uses_rt    = 1'b1;
      hif.IDEX_regwrite = 1'b1;
      hif.IDEX_wreg     = 5'd9;
      hif.ID_taken      = 1'b1;
      ctl("br", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("br.stall_cnt", 32'(hif.stall_cnt), 32'd2);
      hif.IDEX_wreg = 5'd3;
      ctl("brfl", 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      check("brfl.flush_cnt", 32'(hif.flush_cnt), 32'd1);
      clear_in();

      // branch on a load still in MEM
      hif.ID_branch     = 1'b1;
      hif.ID_rs         = 5'd5;
      hif.EXMEM_memread = 1'b1;
      hif.EXMEM_wreg    = 5'd5;
      ctl("brmem", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("brmem.stall_cnt", 32'(hif.stall_cnt), 32'd3);
      clear_in();

      // mul/div busy window
      hif.EX_muldiv_start = 1'b1;
      step();
      hif.EX_muldiv_start = 1'b0;
      hif.ID_hilo_use     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ctl($sformatf("md%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
         check($sformatf("md%0d.md_busy", i), 32'(hif.md_busy), 32'd1);
         step();
      end
      ctl("mddone", 1'b1, 1'b1, 1'b0, 1'b0);
      check("mddone.md_busy", 32'(hif.md_busy), 32'd0);
      check("md.stall_cnt", 32'(hif.stall_cnt), 32'd7);
      step();
      clear_in();

      // reset in the middle of a BUSY countdown
      hif.EX_muldiv_start = 1'b1;
      step();
      hif.EX_muldiv_start = 1'b0;
      step();
      check("mrst.pre_busy", 32'(hif.md_busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mrst.md_busy",   32'(hif.md_busy),   32'd0);
      check("mrst.IF_flush",  32'(hif.IF_flush),  32'd1);
      check("mrst.stall_cnt", 32'(hif.stall_cnt), 32'd0);
      step();
      rst             = 1'b0;
      hif.ID_hilo_use = 1'b1;
      ctl("mrst.post", 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check("mrst.post_cnt", 32'(hif.stall_cnt), 32'd0);
      clear_in();

      // counter wrap at 4 bits: 17 stalls -> 1
      hif.IDEX_memread = 1'b1;
      hif.IDEX_wreg    = 5'd8;
      hif.ID_rs        = 5'd8;
      for (int i = 0; i < 17; i++) step();
      check("wrap.stall_cnt", 32'(hif.stall_cnt), 32'd1);
      check("wrap.flush_cnt", 32'(hif.flush_cnt), 32'd0);
      clear_in();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
